banked_dpram: RTL and testbench
===============================

Name: banked_dpram

Overview:
- Parametrised dual-port, multi-bank synchronous RAM; successor to the two-bank data/program memory used by the CPU datapath and the VGA/IO fabric.
- Address splits into bank select (MSBs) and in-bank offset; bank select is registered so it stays aligned with the 1-cycle synchronous read.
- Adds a hardware zero-clear sequencer, write-collision arbitration with a flag, and a selectable same-port read-during-write mode.

Parameters:
DATA_WIDTH, 16, word width in bits
ADDR_WIDTH, 10, total word address width
NUM_BANKS, 2, bank count; power of two, 1..2^(ADDR_WIDTH-1); BANK_BITS = log2(NUM_BANKS), OFS_BITS = ADDR_WIDTH-BANK_BITS
RDW_MODE, 0, same-port read-during-write: 0 = old data (read-first), 1 = new data (write-first)
CLEAR_ON_RESET, 1, 1 = run clear sequence automatically after reset release

Ports:
clk  in  1  single clock, rising edge
reset_n  in  1  asynchronous, active-low reset
data_a  in  DATA_WIDTH  port A write data
data_b  in  DATA_WIDTH  port B write data
addr_a  in  ADDR_WIDTH  port A word address
addr_b  in  ADDR_WIDTH  port B word address
we_a  in  1  port A write enable
we_b  in  1  port B write enable
clear  in  1  start clear sequence; sampled only in READY
q_a_out  out  DATA_WIDTH  port A read data
q_b_out  out  DATA_WIDTH  port B read data
busy  out  1  high while clearing; user accesses ignored
collision  out  1  one-cycle pulse, same-address dual write occurred

Behaviour:
- Address map: bank = addr[ADDR_WIDTH-1 -: BANK_BITS]; offset = addr[OFS_BITS-1:0]. NUM_BANKS=1: no bank bits, whole address is offset.
- Storage is an inferred per-bank array, 2^OFS_BITS x DATA_WIDTH; contents not affected by reset_n except via the clear sequence.
- Read latency 1 cycle: address at edge N gives data on q_*_out after edge N; held until the next edge. Bank select registered alongside, muxes the bank outputs.
- Writes take effect at the edge where we_* is high. Only the addressed bank is written.
- Same-port read-during-write: RDW_MODE 0 returns prior contents; 1 returns data_* written.
- Cross-port (A writes X, B reads X same edge): reader always gets old data, both modes.
- Dual write, same full address, READY: port A data stored, B dropped; collision = 1 for exactly the next cycle. Different addresses: both written, no flag.
- FSM states: CLEAR, READY.
  - reset_n low: state = CLEAR if CLEAR_ON_RESET else READY; counter = 0; q_a_out = q_b_out = 0; collision = 0; busy = 1 if CLEAR_ON_RESET else 0.
  - CLEAR: each cycle writes 0 to offset=counter in every bank; counter++. After the write at counter = 2^OFS_BITS-1, go to READY; busy falls on that same edge. Duration 2^OFS_BITS cycles.
  - CLEAR: we_a/we_b/clear ignored; q outputs forced 0; collision held 0.
  - READY: clear=1 at an edge -> CLEAR, counter = 0, busy = 1 from next cycle. The access presented with clear is still performed.
- reset_n asserted mid-clear: immediately aborts; on release the sequence restarts from offset 0 (if CLEAR_ON_RESET).
- Counter width OFS_BITS+1; no wrap past end; no bank-select overflow for any address.

Test Plan:
- Reset release, defaults (1024 words, 2 banks): busy = 1 for exactly 512 cycles, then 0. Read 0x000, 0x1FF, 0x200, 0x3FF -> all 0x0000.
- Bank select latency: write 0x1234 @0x005, 0xABCD @0x205. Back-to-back reads 0x005, 0x205 on A -> q_a_out 0x1234 then 0xABCD, each exactly one cycle after its address, no mixing.
- Dual write same address: A=0x1111, B=0x2222 @0x010 -> collision high one cycle. Read 0x010 -> 0x1111. Different addresses -> both stored, collision 0.
- RDW: 0x00AA at 0x020, then A writes 0x00BB @0x020 while reading. RDW_MODE 0 -> q_a_out 0x00AA; RDW_MODE 1 -> 0x00BB. Port B reading 0x020 same edge -> 0x00AA in both modes.
- Mid-clear reset: pulse reset_n low at clear cycle 100 -> busy stays 1, full 512-cycle sweep reruns. Writes during busy not stored (read back 0 afterwards).
- clear input: fill nonzero data, assert clear one cycle -> busy 512 cycles, all locations read 0. Repeat with NUM_BANKS=4, ADDR_WIDTH=10 -> busy 256 cycles.

Source files
------------

// File: rtl/banked_dpram.sv
// Dual-port, multi-bank synchronous RAM. It adds a hardware zero-clear sequencer,
// same-address write-collision arbitration and a selectable same-port read-during-write mode.
module banked_dpram #(
   parameter int DATA_WIDTH     = 16,
   parameter int ADDR_WIDTH     = 10,
   parameter int NUM_BANKS      = 2,
   parameter int RDW_MODE       = 0,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [DATA_WIDTH-1:0] data_a,
   input  logic [DATA_WIDTH-1:0] data_b,
   input  logic [ADDR_WIDTH-1:0] addr_a,
   input  logic [ADDR_WIDTH-1:0] addr_b,
   input  logic                  we_a,
   input  logic                  we_b,
   input  logic                  clear,
   output logic [DATA_WIDTH-1:0] q_a_out,
   output logic [DATA_WIDTH-1:0] q_b_out,
   output logic                  busy,
   output logic                  collision
);

   localparam int BANK_BITS = $clog2(NUM_BANKS);
   localparam int OFS_BITS  = ADDR_WIDTH - BANK_BITS;
   localparam int BSEL_W    = (BANK_BITS > 0) ? BANK_BITS : 1;
   localparam int DEPTH     = 1 << OFS_BITS;
   localparam logic [OFS_BITS:0] LAST_OFS = (OFS_BITS+1)'(DEPTH - 1);

   typedef enum logic {ST_CLEAR, ST_READY} state_t;

   state_t                r_state, w_next_state;
   logic [OFS_BITS:0]     r_count, w_next_count;
   logic                  w_ready;
   logic [BSEL_W-1:0]     w_bank_a, w_bank_b;
   logic [OFS_BITS-1:0]   w_ofs_a, w_ofs_b, w_clr_ofs;
   logic                  w_collide;
   logic [BSEL_W-1:0]     r_bsel_a, r_bsel_b;
   logic                  r_valid;
   logic                  r_collision;
   logic [DATA_WIDTH-1:0] w_bank_q_a [NUM_BANKS];
   logic [DATA_WIDTH-1:0] w_bank_q_b [NUM_BANKS];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
         r_count <= '0;
      end else begin
         r_state <= w_next_state;
         r_count <= w_next_count;
      end
   end

   // The counter is one bit wider than the offset, so the final increment lands on DEPTH instead of wrapping.
   always_comb begin
      w_next_state = r_state;
      w_next_count = r_count;
      case (r_state)
         ST_CLEAR: begin
            w_next_count = r_count + 1'b1;
            if (r_count == LAST_OFS) begin
               w_next_state = ST_READY;
            end
         end
         ST_READY: begin
            if (clear) begin
               w_next_state = ST_CLEAR;
               w_next_count = '0;
            end
         end
         default: w_next_state = ST_READY;
      endcase
   end

   assign w_ready = (r_state == ST_READY);
   assign busy    = (r_state == ST_CLEAR);

   generate
      if (BANK_BITS > 0) begin : g_bsel
         assign w_bank_a = addr_a[ADDR_WIDTH-1 -: BANK_BITS];
         assign w_bank_b = addr_b[ADDR_WIDTH-1 -: BANK_BITS];
      end else begin : g_nobsel
         assign w_bank_a = '0;
         assign w_bank_b = '0;
      end
   endgenerate

   assign w_ofs_a   = addr_a[OFS_BITS-1:0];
   assign w_ofs_b   = addr_b[OFS_BITS-1:0];
   assign w_clr_ofs = r_count[OFS_BITS-1:0];
   assign w_collide = w_ready && we_a && we_b && (addr_a == addr_b);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_bsel_a    <= '0;
         r_bsel_b    <= '0;
         r_valid     <= 1'b0;
         r_collision <= 1'b0;
      end else begin
         r_bsel_a    <= w_bank_a;
         r_bsel_b    <= w_bank_b;
         r_valid     <= w_ready;
         r_collision <= w_collide;
      end
   end

   // Each bank owns its storage and read registers. Port B gives way to port A on an exact-address clash.
   for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
      localparam logic [BSEL_W-1:0] BANK_ID = BSEL_W'(b);

      logic [DATA_WIDTH-1:0] r_mem [DEPTH];
      logic [DATA_WIDTH-1:0] r_rd_a, r_rd_b;
      logic                  w_hit_a, w_hit_b;

      assign w_hit_a = w_ready && we_a && (w_bank_a == BANK_ID);
      assign w_hit_b = w_ready && we_b && (w_bank_b == BANK_ID);

      always_ff @(posedge clk) begin
         if (!w_ready) begin
            r_mem[w_clr_ofs] <= '0;
         end else begin
            if (w_hit_a) begin
               r_mem[w_ofs_a] <= data_a;
            end
            if (w_hit_b && !w_collide) begin
               r_mem[w_ofs_b] <= data_b;
            end
         end
         r_rd_a <= (RDW_MODE != 0 && w_hit_a) ? data_a : r_mem[w_ofs_a];
         r_rd_b <= (RDW_MODE != 0 && w_hit_b) ? data_b : r_mem[w_ofs_b];
      end

      assign w_bank_q_a[b] = r_rd_a;
      assign w_bank_q_b[b] = r_rd_b;
   end

   // The registered bank select stays aligned with the one-cycle read. Reads issued while clearing come back as zero.
   assign q_a_out   = r_valid ? w_bank_q_a[r_bsel_a] : '0;
   assign q_b_out   = r_valid ? w_bank_q_b[r_bsel_b] : '0;
   assign collision = r_collision;

endmodule

// File: tb/tb_banked_dpram.sv
// Self-checking bench for banked_dpram. It runs a 2-bank read-first instance and a 4-bank write-first instance
// side by side against a flat-memory reference model.
module tb_banked_dpram;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [15:0] data_a, data_b;
   logic [9:0]  addr_a, addr_b;
   logic        we_a, we_b, clear;

   logic [15:0] qA0, qB0, qA1, qB1;
   logic        busy0, busy1, coll0, coll1;

   int testsRun    = 0;
   int testsFailed = 0;

   logic [15:0] mMem [2][1024];
   bit          mClearing [2];
   int          mCnt [2];
   logic [15:0] expQA [2];
   logic [15:0] expQB [2];
   logic        expBusy [2];
   logic        expColl [2];
   logic [9:0]  lastAddr;

   always #5 clk = ~clk;

   banked_dpram #(.DATA_WIDTH(16), .ADDR_WIDTH(10), .NUM_BANKS(2), .RDW_MODE(0), .CLEAR_ON_RESET(1)) dut0 (
      .clk(clk), .reset_n(reset_n), .data_a(data_a), .data_b(data_b), .addr_a(addr_a), .addr_b(addr_b),
      .we_a(we_a), .we_b(we_b), .clear(clear), .q_a_out(qA0), .q_b_out(qB0), .busy(busy0), .collision(coll0));

   banked_dpram #(.DATA_WIDTH(16), .ADDR_WIDTH(10), .NUM_BANKS(4), .RDW_MODE(1), .CLEAR_ON_RESET(1)) dut1 (
      .clk(clk), .reset_n(reset_n), .data_a(data_a), .data_b(data_b), .addr_a(addr_a), .addr_b(addr_b),
      .we_a(we_a), .we_b(we_b), .clear(clear), .q_a_out(qA1), .q_b_out(qB1), .busy(busy1), .collision(coll1));

   function automatic int depthOf(input int i);
      return (i == 0) ? 512 : 256;
   endfunction

   function automatic int banksOf(input int i);
      return (i == 0) ? 2 : 4;
   endfunction

   function automatic bit rdwOf(input int i);
      return (i == 0) ? 1'b0 : 1'b1;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   // The model works on a flat 1024-word memory. A clear step zeroes offset cnt in every bank at once.
   task automatic modelStep(input int i);
      if (!reset_n) begin
         mClearing[i] = 1'b1;
         mCnt[i]      = 0;
         expQA[i]     = '0;
         expQB[i]     = '0;
         expColl[i]   = 1'b0;
         expBusy[i]   = 1'b1;
      end else if (mClearing[i]) begin
         for (int k = 0; k < banksOf(i); k++) mMem[i][k*depthOf(i) + mCnt[i]] = '0;
         mCnt[i]++;
         if (mCnt[i] == depthOf(i)) mClearing[i] = 1'b0;
         expQA[i]   = '0;
         expQB[i]   = '0;
         expColl[i] = 1'b0;
         expBusy[i] = mClearing[i];
      end else begin
         expQA[i]   = (rdwOf(i) && we_a) ? data_a : mMem[i][addr_a];
         expQB[i]   = (rdwOf(i) && we_b) ? data_b : mMem[i][addr_b];
         expColl[i] = we_a && we_b && (addr_a == addr_b);
         if (we_b) mMem[i][addr_b] = data_b;
         if (we_a) mMem[i][addr_a] = data_a;
         if (clear) begin
            mClearing[i] = 1'b1;
            mCnt[i]      = 0;
         end
         expBusy[i] = mClearing[i];
      end
   endtask

   initial begin
      for (int i = 0; i < 2; i++)
         for (int a = 0; a < 1024; a++) mMem[i][a] = '0;
   end

   always @(posedge clk) begin
      modelStep(0);
      modelStep(1);
      #1;
      checkOutput("dut0.q_a_out", 32'(qA0), 32'(expQA[0]));
      checkOutput("dut0.q_b_out", 32'(qB0), 32'(expQB[0]));
      checkOutput("dut0.busy", 32'(busy0), 32'(expBusy[0]));
      checkOutput("dut0.collision", 32'(coll0), 32'(expColl[0]));
      checkOutput("dut1.q_a_out", 32'(qA1), 32'(expQA[1]));
      checkOutput("dut1.q_b_out", 32'(qB1), 32'(expQB[1]));
      checkOutput("dut1.busy", 32'(busy1), 32'(expBusy[1]));
      checkOutput("dut1.collision", 32'(coll1), 32'(expColl[1]));
   end

   task automatic applyStimulus(input logic wa, input logic [9:0] aa, input logic [15:0] da,
                                input logic wb, input logic [9:0] ab, input logic [15:0] db, input logic clr);
      @(negedge clk);
      we_a = wa; addr_a = aa; data_a = da;
      we_b = wb; addr_b = ab; data_b = db;
      clear = clr;
      @(posedge clk);
      #2;
   endtask

   task automatic idle();
      applyStimulus(1'b0, 10'h000, 16'h0000, 1'b0, 10'h000, 16'h0000, 1'b0);
   endtask

   // Counts edges until each busy falls. It may fire random writes only while both instances are still clearing.
   task automatic measureBusy(input bit doWrites, output int d0, output int d1);
      d0 = 0;
      d1 = 0;
      for (int k = 1; k <= 2000 && (d0 == 0 || d1 == 0); k++) begin
         @(negedge clk);
         we_a   = doWrites && busy1;
         addr_a = 10'($urandom_range(0, 1023));
         data_a = 16'($urandom_range(1, 65535));
         we_b   = doWrites && busy1;
         addr_b = 10'($urandom_range(0, 1023));
         data_b = 16'($urandom_range(1, 65535));
         clear  = 1'b0;
         if (we_a) lastAddr = addr_a;
         @(posedge clk);
         #2;
         if (!busy0 && d0 == 0) d0 = k;
         if (!busy1 && d1 == 0) d1 = k;
      end
   endtask

   task automatic waitReady();
      int n = 0;
      while ((busy0 || busy1) && n < 700) begin
         idle();
         n++;
      end
      checkOutput("waitReady busy0", 32'(busy0), 32'd0);
      checkOutput("waitReady busy1", 32'(busy1), 32'd0);
   endtask

   task automatic checkBoth(input string name, input logic [15:0] e0a, input logic [15:0] e1a,
                            input logic [15:0] e0b, input logic [15:0] e1b);
      checkOutput({name, " dut0.qa"}, 32'(qA0), 32'(e0a));
      checkOutput({name, " dut1.qa"}, 32'(qA1), 32'(e1a));
      checkOutput({name, " dut0.qb"}, 32'(qB0), 32'(e0b));
      checkOutput({name, " dut1.qb"}, 32'(qB1), 32'(e1b));
   endtask

   initial begin
      int d0, d1;
      logic [9:0] aa, ab;
      reset_n = 1'b0;
      clear = 1'b0; we_a = 1'b0; we_b = 1'b0;
      addr_a = '0; addr_b = '0; data_a = '0; data_b = '0;
      lastAddr = '0;
      repeat (3) @(posedge clk);
      #2;
      checkOutput("reset busy0", 32'(busy0), 32'd1);
      checkOutput("reset q_a0", 32'(qA0), 32'd0);
      reset_n = 1'b1;

      measureBusy(1'b0, d0, d1);
      checkOutput("initial clear length dut0", 32'(d0), 32'd512);
      checkOutput("initial clear length dut1", 32'(d1), 32'd256);
      applyStimulus(1'b0, 10'h000, 16'h0, 1'b0, 10'h1FF, 16'h0, 1'b0);
      checkBoth("cleared 000/1FF", 16'h0, 16'h0, 16'h0, 16'h0);
      applyStimulus(1'b0, 10'h200, 16'h0, 1'b0, 10'h3FF, 16'h0, 1'b0);
      checkBoth("cleared 200/3FF", 16'h0, 16'h0, 16'h0, 16'h0);

      applyStimulus(1'b1, 10'h005, 16'h1234, 1'b0, 10'h000, 16'h0, 1'b0);
      applyStimulus(1'b1, 10'h205, 16'hABCD, 1'b0, 10'h000, 16'h0, 1'b0);
      applyStimulus(1'b0, 10'h005, 16'h0, 1'b0, 10'h000, 16'h0, 1'b0);
      checkBoth("bank read 005", 16'h1234, 16'h1234, 16'h0, 16'h0);
      applyStimulus(1'b0, 10'h205, 16'h0, 1'b0, 10'h000, 16'h0, 1'b0);
      checkBoth("bank read 205", 16'hABCD, 16'hABCD, 16'h0, 16'h0);

      applyStimulus(1'b1, 10'h010, 16'h1111, 1'b1, 10'h010, 16'h2222, 1'b0);
      checkOutput("collision dut0", 32'(coll0), 32'd1);
      checkOutput("collision dut1", 32'(coll1), 32'd1);
      applyStimulus(1'b0, 10'h010, 16'h0, 1'b0, 10'h010, 16'h0, 1'b0);
      checkOutput("collision drop dut0", 32'(coll0), 32'd0);
      checkBoth("collision winner", 16'h1111, 16'h1111, 16'h1111, 16'h1111);
      applyStimulus(1'b1, 10'h011, 16'h3333, 1'b1, 10'h012, 16'h4444, 1'b0);
      checkOutput("no collision dut0", 32'(coll0), 32'd0);
      applyStimulus(1'b0, 10'h011, 16'h0, 1'b0, 10'h012, 16'h0, 1'b0);
      checkBoth("dual write diff", 16'h3333, 16'h3333, 16'h4444, 16'h4444);

      applyStimulus(1'b1, 10'h020, 16'h00AA, 1'b0, 10'h000, 16'h0, 1'b0);
      applyStimulus(1'b1, 10'h020, 16'h00BB, 1'b0, 10'h020, 16'h0, 1'b0);
      checkBoth("read during write", 16'h00AA, 16'h00BB, 16'h00AA, 16'h00AA);
      applyStimulus(1'b0, 10'h020, 16'h0, 1'b0, 10'h020, 16'h0, 1'b0);
      checkBoth("after rdw", 16'h00BB, 16'h00BB, 16'h00BB, 16'h00BB);

      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 1) == 0) aa = 10'($urandom_range(0, 7) + 256 * $urandom_range(0, 3));
         else aa = 10'($urandom_range(0, 1023));
         ab = ($urandom_range(0, 3) == 0) ? aa : 10'($urandom_range(0, 1023));
         applyStimulus(1'($urandom_range(0, 1)), aa, 16'($urandom), 1'($urandom_range(0, 1)), ab,
                       16'($urandom), 1'($urandom_range(0, 999) == 0));
      end

      waitReady();
      applyStimulus(1'b0, 10'h000, 16'h0, 1'b0, 10'h000, 16'h0, 1'b1);
      repeat (100) idle();
      reset_n = 1'b0;
      @(posedge clk);
      #2;
      checkOutput("mid-clear reset busy0", 32'(busy0), 32'd1);
      reset_n = 1'b1;
      measureBusy(1'b1, d0, d1);
      checkOutput("restart clear length dut0", 32'(d0), 32'd512);
      checkOutput("restart clear length dut1", 32'(d1), 32'd256);
      applyStimulus(1'b0, lastAddr, 16'h0, 1'b0, 10'h005, 16'h0, 1'b0);
      checkBoth("busy writes dropped", 16'h0, 16'h0, 16'h0, 16'h0);

      for (int k = 0; k < 512; k++)
         applyStimulus(1'b1, 10'(k), 16'(k) ^ 16'h5A5B, 1'b1, 10'(k + 512), 16'(k) | 16'h8000, 1'b0);
      applyStimulus(1'b0, 10'h001, 16'h0, 1'b0, 10'h201, 16'h0, 1'b0);
      checkBoth("filled", 16'h5A5A, 16'h5A5A, 16'h8001, 16'h8001);
      applyStimulus(1'b0, 10'h000, 16'h0, 1'b0, 10'h000, 16'h0, 1'b1);
      measureBusy(1'b0, d0, d1);
      checkOutput("clear input length dut0", 32'(d0), 32'd512);
      checkOutput("clear input length dut1", 32'(d1), 32'd256);
      for (int k = 0; k < 512; k++) begin
         applyStimulus(1'b0, 10'(k), 16'h0, 1'b0, 10'(k + 512), 16'h0, 1'b0);
         checkBoth("swept zero", 16'h0, 16'h0, 16'h0, 16'h0);
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
